// File: rtl/dpi_call_scheduler.sv
// Round-robin scheduler sharing one foreign-call channel among NUM_REQ requesters.
// One call in flight; WAIT is bounded by TIMEOUT and completion returns to the owner.
module dpi_call_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      call_valid,
    output logic [1:0]                call_op,
    output logic [DATA_W-1:0]         call_data,
    input  logic                      call_ready,
    input  logic                      rsp_valid,
    input  logic [DATA_W-1:0]         rsp_data,
    input  logic                      rsp_err,
    output logic [NUM_REQ-1:0]        done_valid,
    output logic [DATA_W-1:0]         done_data,
    output logic                      done_err,
    output logic [DATA_W-1:0]         int_out,
    output logic                      bool_out,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_SET_INT  = 2'd0;
    localparam logic [1:0] OP_SET_BOOL = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  res_data;
    logic               res_err;
    logic [TMR_W-1:0]   timer;
    logic               timeout_hit;
    logic               take;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand;
    logic [NUM_REQ-1:0] ready_raw;

    logic [1:0]        op_arr   [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op[2*g +: 2];
        assign data_arr[g] = req_data[DATA_W*g +: DATA_W];
    end

    // Scan from rr_ptr upward with wrap; the first live request wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ))
                cand = cand - (PTR_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign take        = (state == S_IDLE) && grant_found;
    assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        ready_raw = '0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    ready_raw[grant_idx] = 1'b1;
                    state_nxt = (op_arr[grant_idx] == OP_RSVD) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: if (call_ready) state_nxt = S_WAIT;
            S_WAIT:  if (rsp_valid || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            timer    <= '0;
            int_out  <= '0;
            bool_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_ISSUE)
                timer <= '0;
            else if (state == S_WAIT)
                timer <= timer + 1'b1;
            if (state == S_DONE) begin
                rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                if (!res_err) begin
                    if (op_q == OP_SET_INT)  int_out  <= res_data;
                    if (op_q == OP_SET_BOOL) bool_out <= res_data[0];
                end
            end
        end
    end

    // Result defaults to "error, zero" at accept so reserved ops and timeouts need no extra path.
    always_ff @(posedge clk) begin
        if (take) begin
            owner    <= grant_idx;
            op_q     <= op_arr[grant_idx];
            data_q   <= data_arr[grant_idx];
            res_data <= '0;
            res_err  <= 1'b1;
        end else if (state == S_WAIT) begin
            if (rsp_valid) begin
                res_data <= rsp_data;
                res_err  <= rsp_err;
            end else if (timeout_hit) begin
                res_data <= '0;
                res_err  <= 1'b1;
            end
        end
    end

    assign req_ready  = rst ? '0 : ready_raw;
    assign call_valid = (state == S_ISSUE);
    assign call_op    = call_valid ? op_q : 2'd0;
    assign call_data  = call_valid ? data_q : '0;
    assign done_valid = (state == S_DONE) ? (NUM_REQ'(1) << owner) : '0;
    assign done_data  = (state == S_DONE) ? res_data : '0;
    assign done_err   = (state == S_DONE) ? res_err : 1'b0;
    assign busy       = (state != S_IDLE);

endmodule
